// File: rtl/mdu_iter_pkg.sv
// mdu_defs: op and state encodings shared by mdu_iter and mdu_sign_fix
package mdu_defs;
    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} mdu_state_e;
    function automatic logic mdu_is_div(input logic [1:0] op);
        return op == MDU_DIV || op == MDU_DIVU;
    endfunction
    function automatic logic mdu_is_signed(input logic [1:0] op);
        return op == MDU_MULT || op == MDU_DIV;
    endfunction
endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: turns the unsigned magnitude result into final hi/lo values
module mdu_sign_fix
    import mdu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_raw,
    input  logic [1:0]         i_op,
    input  logic               i_neg_q,
    input  logic               i_neg_r,
    input  logic               i_dz,
    output logic [WIDTH-1:0]   o_hi,
    output logic [WIDTH-1:0]   o_lo
);
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    assign w_prod = i_neg_q ? -i_raw : i_raw;
    assign w_q = i_neg_q ? -i_raw[WIDTH-1:0] : i_raw[WIDTH-1:0];
    assign w_r = i_neg_r ? -i_raw[2*WIDTH-1:WIDTH] : i_raw[2*WIDTH-1:WIDTH];
    // divide by zero bypasses correction; divides fix quotient and remainder independently
    assign {o_hi, o_lo} = i_dz ? i_raw : mdu_is_div(i_op) ? {w_r, w_q} : w_prod;
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO registers; MDU_EARLY_OUT_EN enables multiply early-out
module mdu_iter
    import mdu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    mdu_state_e           r_state;
    logic [1:0]           r_op;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mpl;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_dz;
    logic                 r_done;
    logic                 w_sgn;
    logic                 w_div;
    logic                 w_last;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_sub;
    logic [2*WIDTH-1:0]   w_step;
    logic [2*WIDTH-1:0]   w_acc;
    logic [2*WIDTH-1:0]   w_raw;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;
    assign w_sgn   = mdu_is_signed(op);
    assign w_a_mag = (w_sgn && a[WIDTH-1]) ? -a : a;
    assign w_b_mag = (w_sgn && b[WIDTH-1]) ? -b : b;
    assign w_div   = mdu_is_div(r_op);
    // multiply: add the multiplicand into the top half, shift the pair right
    assign w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mpl[0] ? r_mcand : {WIDTH{1'b0}}};
    // divide: {rem, dividend} shifts left, trial-subtract the divisor from the widened remainder
    assign w_sub  = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_mcand};
    assign w_step = w_div ? (w_sub[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                          : {w_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1})
                          : {w_add, r_acc[WIDTH-1:1]};
`ifdef MDU_EARLY_OUT_EN
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || (!w_div && r_mpl[WIDTH-1:1] == '0);
    assign w_acc  = w_div ? r_acc : r_acc >> (CNT_W'(WIDTH) - r_cnt);
`else
    assign w_last = r_cnt == CNT_W'(WIDTH - 1);
    assign w_acc  = r_acc;
`endif
    assign w_raw = r_dz ? {r_a, {WIDTH{1'b1}}} : w_acc;
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .i_raw   (w_raw),
        .i_op    (r_op),
        .i_neg_q (r_neg_q),
        .i_neg_r (r_neg_r),
        .i_dz    (r_dz),
        .o_hi    (w_fix_hi),
        .o_lo    (w_fix_lo)
    );
    // control FSM, datapath iteration and HI/LO writes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_op    <= op;
                        r_acc   <= op[1] ? {{WIDTH{1'b0}}, w_a_mag} : '0;
                        r_mcand <= op[1] ? w_b_mag : w_a_mag;
                        r_mpl   <= w_b_mag;
                        r_a     <= a;
                        r_neg_q <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r <= (op == MDU_DIV) && a[WIDTH-1];
                        r_dz    <= op[1] && (b == '0);
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_step;
                    r_mpl <= r_mpl >> 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) r_state <= FIX;
                end
                FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign busy = r_state != IDLE;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and random checks of mdu_iter with an expected-result queue
module tb_mdu_iter;
    import mdu_defs::*;
    localparam int WIDTH = 32;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic hi_we = 1'b0;
    logic lo_we = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic busy;
    logic done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [63:0] sb[$];
    int total = 0;
    int bad = 0;
    int n;
    int nb;
    int pulses;

    mdu_iter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == MDU_MULT) return sx * sy;
        if (o == MDU_MULTU) return {32'b0, x} * {32'b0, y};
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == MDU_DIVU) return {x % y, x / y};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic wait_done(input string tag, input int n0, output int n_o, output int nb_o);
        logic [63:0] e;
        n_o = n0;
        nb_o = 0;
        while (!done && n_o < 100) begin
            if (busy) nb_o++;
            @(negedge clk);
            n_o++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (done) check({tag, "_hilo"}, {hi, lo}, e);
        end
        check({tag, "_lat"}, 64'(n_o), 64'(WIDTH + 1));
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] e, output int nb_o);
        int n_l;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        wait_done(tag, 0, n_l, nb_o);
        @(negedge clk);
        check({tag, "_after"}, {62'b0, done, busy}, 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ctl", {62'b0, busy, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", {hi, lo}, 64'h1234_5678_0000_0000);
        lo_we = 1'b1;
        wdata = 32'h0BAD_F00D;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", {hi, lo}, 64'h1234_5678_0BAD_F00D);
        do_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, nb);
        check("multu_busy_cycles", 64'(nb), 64'd33);
        do_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, nb);
        do_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, nb);
        do_op("divu", MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, nb);
        do_op("divu_zero", MDU_DIVU, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, nb);
        do_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, nb);
        sb.push_back({32'd0, 32'd42});
        @(negedge clk);
        start = 1'b1;
        op = MDU_MULTU;
        a = 32'd6;
        b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        op = MDU_DIVU;
        a = 32'd1;
        b = 32'd1;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mt_busy_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
        check("mt_busy_busy", 64'(busy), 64'd1);
        wait_done("busy_restart", 6, n, nb);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("busy_restart_pulses", 64'(pulses), 64'd0);
        @(negedge clk);
        start = 1'b1;
        op = MDU_DIV;
        a = 32'd1000;
        b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_ctl", {62'b0, busy, done}, 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("midrst_quiet", 64'(pulses), 64'd0);
        do_op("multu_after_rst", MDU_MULTU, 32'd3, 32'd5, 64'd15, nb);
        sb.push_back(64'd6);
        @(negedge clk);
        start = 1'b1;
        op = MDU_MULTU;
        a = 32'd2;
        b = 32'd3;
        hi_we = 1'b1;
        wdata = 32'hABCD_0123;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        check("start_mthi_hi", {hi, lo}, {32'hABCD_0123, 32'd15});
        wait_done("start_mthi", 0, n, nb);
        for (int i = 0; i < 12; i++) begin
            logic [1:0] o;
            logic [31:0] x;
            logic [31:0] y;
            o = 2'(i % 4);
            x = $urandom;
            y = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 4 == 2 && i > 4) y = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            do_op("rand", o, x, y, model(o, x, y), nb);
        end
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
